// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between the request arbiter (master) and the bridge/completer (slave).
interface apb_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB requester port among NUM_REQ clients.
// Optional ACCESS-phase timeout is built only when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_pstrb,
  input  logic [NUM_REQ*3-1:0]            req_pprot,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic                            resp_err,
  apb_req_arbiter_if.master               apb
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      owner;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_found;
  logic [IDX_W:0]        cand;
  logic                  accept;
  logic                  access_timeout;

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_strb;
  logic [2:0]            sel_prot;
  logic                  sel_aligned;

  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  psel_c;
  logic                  penable_c;

  // Search starts one past the last-served client so it drops to lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign accept      = (state == IDLE) && grant_found;
  assign sel_write   = req_write[grant_idx];
  assign sel_addr    = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata   = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_strb    = req_pstrb[grant_idx*STRB_W +: STRB_W];
  assign sel_prot    = req_pprot[grant_idx*3 +: 3];
  assign sel_aligned = (sel_addr[1:0] == 2'b00);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !apb.pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign access_timeout = (state == ACCESS) && !apb.pready &&
                          (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign access_timeout = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    psel_c     = 1'b0;
    penable_c  = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt = sel_aligned ? SETUP : RESP;
        end
      end
      SETUP: begin
        psel_c    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        if (apb.pready || access_timeout) state_nxt = RESP;
      end
      RESP: begin
        resp_valid[owner] = 1'b1;
        resp_rdata        = rdata_q;
        resp_err          = err_q;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched on accept and held until the next accept.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ptr     <= IDX_W'(NUM_REQ - 1);
      owner   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        ptr     <= grant_idx;
        owner   <= grant_idx;
        write_q <= sel_write;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        strb_q  <= sel_write ? sel_strb : '0;
        prot_q  <= sel_prot;
        if (!sel_aligned) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == ACCESS) begin
        if (apb.pready) begin
          rdata_q <= write_q ? '0 : apb.prdata;
          err_q   <= apb.pslverr;
        end else if (access_timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign apb.psel    = psel_c;
  assign apb.penable = penable_c;
  assign apb.pwrite  = write_q;
  assign apb.paddr   = addr_q;
  assign apb.pwdata  = wdata_q;
  assign apb.pstrb   = strb_q;
  assign apb.pprot   = prot_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: transaction-timeline model plus directed tests.
module tb_apb_req_arbiter;

  localparam int NR  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TOC = 16;
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              pclk = 1'b0;
  logic              preset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_pstrb;
  logic [NR*3-1:0]   req_pprot;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              resp_err;

  apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_req_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pstrb(req_pstrb),
    .req_pprot(req_pprot), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .apb(apb.master)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Completer behaviour per client, set by the stimulus before each request.
  int          cfg_waits [NR];
  logic [31:0] cfg_rdata [NR];
  bit          cfg_err   [NR];

  // Model: each accepted request becomes a timeline of cycles relative to its accept cycle.
  bit          m_active = 0, hold_pend = 0;
  int          m_acc, m_resp, m_client, m_waits;
  int          m_ptr = NR - 1;
  bit          m_write, m_aligned, m_timeout, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  bit          h_write = 0;
  logic [31:0] h_addr = 0, h_wdata = 0;
  logic [3:0]  h_strb = 0;
  logic [2:0]  h_prot = 0;

  function automatic int rrPick(input logic [NR-1:0] v, input int ptr);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (ptr + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge pclk) begin
    logic [NR-1:0] e_ready, e_resp;
    bit e_psel, e_pen, in_resp, in_access, ready_now;
    int g;
    e_ready = '0; e_resp = '0; e_psel = 0; e_pen = 0; in_resp = 0;
    in_access = 0; ready_now = 0;
    if (preset !== 1'b0) begin
      m_active = 0; hold_pend = 0; m_ptr = NR - 1;
      h_write = 0; h_addr = 0; h_wdata = 0; h_strb = 0; h_prot = 0;
    end else begin
      if (m_active && cyc > m_resp) m_active = 0;
      if (hold_pend && cyc > m_acc) begin
        h_write = m_write; h_addr = m_addr; h_wdata = m_wdata;
        h_strb = m_strb; h_prot = m_prot; hold_pend = 0;
      end
      if (!m_active) begin
        g = rrPick(req_valid, m_ptr);
        if (g >= 0) begin
          e_ready[g] = 1'b1;
          m_active = 1; hold_pend = 1; m_ptr = g; m_acc = cyc; m_client = g;
          m_write   = req_write[g];
          m_addr    = req_addr[g*AW +: AW];
          m_wdata   = req_wdata[g*DW +: DW];
          m_strb    = m_write ? req_pstrb[g*SW +: SW] : 4'h0;
          m_prot    = req_pprot[g*3 +: 3];
          m_aligned = (m_addr % 4) == 0;
          m_waits   = cfg_waits[g];
          m_timeout = TO_EN && m_aligned && (m_waits >= TOC);
          if (!m_aligned) begin
            m_resp = cyc + 1; m_rdata = 0; m_err = 1;
          end else if (m_timeout) begin
            m_resp = cyc + 2 + TOC; m_rdata = 0; m_err = 1;
          end else begin
            m_resp  = cyc + 3 + m_waits;
            m_rdata = m_write ? 32'h0 : cfg_rdata[g];
            m_err   = cfg_err[g];
          end
        end
      end
      if (m_active && m_aligned) begin
        e_psel    = (cyc > m_acc) && (cyc < m_resp);
        e_pen     = (cyc > m_acc + 1) && (cyc < m_resp);
        in_access = e_pen;
        ready_now = in_access && !m_timeout && (cyc == m_acc + 2 + m_waits);
      end
      if (m_active && cyc == m_resp) begin
        e_resp[m_client] = 1'b1;
        in_resp = 1;
      end
    end
    checkOutput("req_ready", 64'(req_ready), 64'(e_ready));
    checkOutput("resp_valid", 64'(resp_valid), 64'(e_resp));
    checkOutput("psel", 64'(apb.psel), 64'(e_psel));
    checkOutput("penable", 64'(apb.penable), 64'(e_pen));
    checkOutput("paddr", 64'(apb.paddr), 64'(h_addr));
    checkOutput("pwdata", 64'(apb.pwdata), 64'(h_wdata));
    checkOutput("pprot", 64'(apb.pprot), 64'(h_prot));
    if (e_psel || preset !== 1'b0) begin
      checkOutput("pwrite", 64'(apb.pwrite), 64'(h_write));
      checkOutput("pstrb", 64'(apb.pstrb), 64'(h_strb));
    end
    if (in_resp) begin
      checkOutput("resp_rdata", 64'(resp_rdata), 64'(m_rdata));
      checkOutput("resp_err", 64'(resp_err), 64'(m_err));
    end
    apb.pready  = ready_now;
    apb.prdata  = ready_now ? cfg_rdata[m_client] : (32'h5A5A_0000 | 32'(cyc));
    apb.pslverr = ready_now ? cfg_err[m_client] : in_access;
  end

  // Observed DUT events for the hand-computed checks.
  int          mon_acc = 0, mon_first_psel = -1, mon_first_pen = -1, mon_resp = 0;
  int          mon_psel_cnt = 0, mon_pen_cnt = 0, mon_resp_cnt = 0;
  logic [31:0] mon_rdata = 0, mon_pwdata = 0, mon_paddr = 0;
  logic        mon_err = 0;
  logic [3:0]  mon_pstrb = 0;
  logic [2:0]  mon_pprot = 0;
  logic [NR-1:0] mon_resp_vec = 0;
  int          grant_log[$];

  always @(negedge pclk) begin
    if (preset === 1'b0) begin
      if (|req_ready) begin
        mon_acc = cyc; mon_first_psel = -1; mon_first_pen = -1;
        mon_psel_cnt = 0; mon_pen_cnt = 0;
        for (int c = 0; c < NR; c++) if (req_ready[c]) grant_log.push_back(c);
      end
      if (apb.psel) begin
        mon_psel_cnt++;
        if (mon_first_psel < 0) mon_first_psel = cyc;
      end
      if (apb.penable) begin
        mon_pen_cnt++;
        if (mon_first_pen < 0) begin
          mon_first_pen = cyc; mon_pwdata = apb.pwdata; mon_paddr = apb.paddr;
          mon_pstrb = apb.pstrb; mon_pprot = apb.pprot;
        end
      end
      if (|resp_valid) begin
        mon_resp = cyc; mon_resp_vec = resp_valid; mon_rdata = resp_rdata;
        mon_err = resp_err; mon_resp_cnt++;
      end
    end
  end

  task automatic applyStimulus(input int c, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [2:0] prot, input int waits,
                               input logic [31:0] rdata, input bit err);
    bit seen;
    cfg_waits[c] = waits; cfg_rdata[c] = rdata; cfg_err[c] = err;
    req_write[c] = wr;
    req_addr[c*AW +: AW]  = addr;
    req_wdata[c*DW +: DW] = wdata;
    req_pstrb[c*SW +: SW] = strb;
    req_pprot[c*3 +: 3]   = prot;
    req_valid[c] = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge pclk);
      seen = req_ready[c];
    end
    checkOutput("grant_seen", 64'(seen), 64'(1));
    @(posedge pclk); #2;
    req_valid[c] = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge pclk);
      seen = resp_valid[c];
    end
    checkOutput("resp_seen", 64'(seen), 64'(1));
    @(posedge pclk); #2;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, r, t3_exp[4];
    bit seen;
    t3_exp = '{0, 1, 0, 1};
    preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_pstrb = '0; req_pprot = '0;
    for (int c = 0; c < NR; c++) begin cfg_waits[c] = 0; cfg_rdata[c] = 0; cfg_err[c] = 0; end
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    repeat (3) @(posedge pclk); #2;
    checkOutput("reset_psel", 64'(apb.psel), 64'(0));
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'(0));
    preset = 1'b0;

    $display("[TB] T1 client0 read 0x4, zero wait");
    applyStimulus(0, 0, 32'h4, 32'h0, 4'h0, 3'b000, 0, 32'hDEADBEEF, 0);
    checkOutput("t1_psel_lat", 64'(mon_first_psel - mon_acc), 64'(1));
    checkOutput("t1_pen_lat", 64'(mon_first_pen - mon_acc), 64'(2));
    checkOutput("t1_resp_lat", 64'(mon_resp - mon_acc), 64'(3));
    checkOutput("t1_resp_vec", 64'(mon_resp_vec), 64'(2'b01));
    checkOutput("t1_rdata", 64'(mon_rdata), 64'(32'hDEADBEEF));
    checkOutput("t1_err", 64'(mon_err), 64'(0));

    $display("[TB] T2 client1 write 0x10 with three wait states");
    applyStimulus(1, 1, 32'h10, 32'hFFFFFFFF, 4'hF, 3'b000, 3, 32'h0, 0);
    checkOutput("t2_resp_lat", 64'(mon_resp - mon_acc), 64'(6));
    checkOutput("t2_psel_cycles", 64'(mon_psel_cnt), 64'(5));
    checkOutput("t2_pen_cycles", 64'(mon_pen_cnt), 64'(4));
    checkOutput("t2_pwdata", 64'(mon_pwdata), 64'(32'hFFFFFFFF));
    checkOutput("t2_paddr", 64'(mon_paddr), 64'(32'h10));
    checkOutput("t2_pstrb", 64'(mon_pstrb), 64'(4'hF));
    checkOutput("t2_resp_vec", 64'(mon_resp_vec), 64'(2'b10));
    checkOutput("t2_err", 64'(mon_err), 64'(0));

    $display("[TB] T3 both clients requesting after reset");
    @(posedge pclk); #2 preset = 1'b1;
    @(posedge pclk); #2 preset = 1'b0;
    cfg_waits[0] = 0; cfg_rdata[0] = 32'h11110000; cfg_err[0] = 0;
    cfg_waits[1] = 0; cfg_rdata[1] = 32'h22220000; cfg_err[1] = 0;
    req_write = '0;
    req_addr  = {32'h200, 32'h100};
    req_pprot = {3'b010, 3'b001};
    s = grant_log.size();
    req_valid = 2'b11;
    for (int i = 0; i < 80 && grant_log.size() < s + 4; i++) @(negedge pclk);
    @(posedge pclk); #2 req_valid = '0;
    repeat (6) @(posedge pclk); #2;
    checkOutput("t3_grant_count", 64'(grant_log.size() - s), 64'(4));
    if (grant_log.size() >= s + 4)
      for (int i = 0; i < 4; i++) checkOutput("t3_grant_order", 64'(grant_log[s+i]), 64'(t3_exp[i]));

    $display("[TB] T4 client0 unaligned read 0x3");
    applyStimulus(0, 0, 32'h3, 32'h0, 4'h0, 3'b000, 0, 32'h12345678, 0);
    checkOutput("t4_psel_cycles", 64'(mon_psel_cnt), 64'(0));
    checkOutput("t4_resp_lat", 64'(mon_resp - mon_acc), 64'(1));
    checkOutput("t4_err", 64'(mon_err), 64'(1));
    checkOutput("t4_rdata", 64'(mon_rdata), 64'(0));

    $display("[TB] T5 client1 read 0x8 with slave error and pprot 7");
    applyStimulus(1, 0, 32'h8, 32'h0, 4'hF, 3'b111, 1, 32'hCAFEF00D, 1);
    checkOutput("t5_err", 64'(mon_err), 64'(1));
    checkOutput("t5_pprot", 64'(mon_pprot), 64'(3'b111));
    checkOutput("t5_pstrb_read", 64'(mon_pstrb), 64'(0));
    checkOutput("t5_resp_lat", 64'(mon_resp - mon_acc), 64'(4));
    checkOutput("t5_rdata", 64'(mon_rdata), 64'(32'hCAFEF00D));

    $display("[TB] T7 long pready stall of 20 cycles");
    applyStimulus(0, 0, 32'h40, 32'h0, 4'h0, 3'b000, 20, 32'h0BADCAFE, 0);
`ifdef APB_ARB_TIMEOUT_EN
    checkOutput("t7_resp_lat", 64'(mon_resp - mon_acc), 64'(18));
    checkOutput("t7_err", 64'(mon_err), 64'(1));
    checkOutput("t7_rdata", 64'(mon_rdata), 64'(0));
`else
    checkOutput("t7_resp_lat", 64'(mon_resp - mon_acc), 64'(23));
    checkOutput("t7_err", 64'(mon_err), 64'(0));
    checkOutput("t7_rdata", 64'(mon_rdata), 64'(32'h0BADCAFE));
`endif

    $display("[TB] T6 reset during ACCESS");
    cfg_waits[0] = 5; cfg_rdata[0] = 32'h55AA55AA; cfg_err[0] = 0;
    req_write[0] = 1'b0; req_addr[0 +: AW] = 32'h20; req_pprot[0 +: 3] = 3'b101;
    req_valid[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge pclk); seen = req_ready[0]; end
    checkOutput("t6_grant_seen", 64'(seen), 64'(1));
    @(posedge pclk); #2 req_valid[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge pclk); seen = apb.penable; end
    checkOutput("t6_access_seen", 64'(seen), 64'(1));
    r = mon_resp_cnt;
    @(posedge pclk); #2 preset = 1'b1;
    #1;
    checkOutput("t6_psel", 64'(apb.psel), 64'(0));
    checkOutput("t6_penable", 64'(apb.penable), 64'(0));
    checkOutput("t6_paddr", 64'(apb.paddr), 64'(0));
    checkOutput("t6_pprot", 64'(apb.pprot), 64'(0));
    repeat (2) @(posedge pclk); #2 preset = 1'b0;
    repeat (10) @(posedge pclk); #2;
    checkOutput("t6_no_resp", 64'(mon_resp_cnt), 64'(r));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
